// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_pkg
// Brief   : Shared types and constants for the instruction-memory loader.
// Revision: 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

   localparam int INSTR_W = 8;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_OVF  = 2'd2,
      ST_RUN  = 2'd3
   } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module  : imem_array
// Brief   : DEPTH x INSTR_W storage, synchronous write, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
module imem_array
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read-before-write: a same-cycle write lands only after the edge.
   assign rdata = mem_q[raddr];

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Brief   : Streams a program image into instruction memory and holds the
//           core in reset until a complete image is present.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               s_valid,
   input  logic [INSTR_W-1:0] s_data,
   input  logic               s_last,
   output logic               s_ready,
   input  logic [AW-1:0]      fetch_addr,
   output logic [INSTR_W-1:0] fetch_data,
   output logic               core_rst,
   output logic               load_done,
   output logic               load_err,
   output logic [AW:0]        word_count
);

   if (AW != $clog2(DEPTH)) begin : g_bad_aw
      $error("imem_loader: AW must equal log2(DEPTH)");
   end

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

   state_t             state_q,  state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]        count_q,  count_d;
   logic               err_q,    err_d;
   logic               we;
   logic               xfer;
   logic [INSTR_W-1:0] rd_word;

   assign s_ready = (state_q == ST_LOAD) || (state_q == ST_OVF);
   assign xfer    = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      we       = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (start) begin
               state_d  = ST_LOAD;
               wr_ptr_d = '0;
               count_d  = '0;
               err_d    = 1'b0;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               we      = 1'b1;
               count_d = count_q + CNT_ONE;
               if (s_last) begin
                  state_d = ST_RUN;
               end else if (wr_ptr_q == LAST_PTR) begin
                  // Memory full: pointer parks on the last slot instead of wrapping.
                  state_d = ST_OVF;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
               end
            end
         end
         ST_OVF: begin
            if (xfer) begin
               err_d = 1'b1;
               if (s_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (s_data),
      .raddr (fetch_addr),
      .rdata (rd_word)
   );

   // Unloaded slots read as NOP so stale contents never reach the core.
   assign fetch_data = ({1'b0, fetch_addr} < count_q) ? rd_word : NOP_INSTR;
   assign core_rst   = (state_q != ST_RUN);
   assign load_done  = (state_q == ST_RUN);
   assign load_err   = err_q;
   assign word_count = count_q;

endmodule : imem_loader
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, default 16, number of 8-bit instruction words held; power of two, at least 4.
REQ-002 Parameter: AW, default 4, address width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  one-cycle pulse that begins a (re)load of the program image.
REQ-006 Port: s_valid  in  1  loader byte stream has a valid word.
REQ-007 Port: s_data  in  8  instruction word: [7:6] opcode, [5:3] rs1/rd, [2:0] rs2/shamt.
REQ-008 Port: s_last  in  1  marks the final word of the image; qualified by s_valid.
REQ-009 Port: s_ready  out  1  block accepts a word this cycle.
REQ-010 Port: fetch_addr  in  AW  word address from the core fetch stage.
REQ-011 Port: fetch_data  out  8  instruction at fetch_addr.
REQ-012 Port: core_rst  out  1  holds the processor pipeline in reset while no valid image is present.
REQ-013 Port: load_done  out  1  image loaded and core released.
REQ-014 Port: load_err  out  1  image exceeded DEPTH words; excess words discarded.
REQ-015 Port: word_count  out  AW+1  number of words stored by the last load (0..DEPTH).

Function
REQ-016 States: IDLE, LOAD, OVF, RUN; state held in one register.
REQ-017 Transfer occurs on a cycle with s_valid=1 and s_ready=1; no other cycle changes memory.
REQ-018 IDLE: s_ready=0, core_rst=1; start=1 -> LOAD next cycle, write pointer and word_count cleared, load_err cleared.
REQ-019 LOAD: s_ready=1, core_rst=1; each transfer writes s_data at mem[wr_ptr], wr_ptr and word_count increment by 1.
REQ-020 LOAD, transfer with s_last=1 -> RUN next cycle (word counted).
REQ-021 LOAD, transfer at wr_ptr=DEPTH-1 with s_last=0 -> OVF next cycle; word_count becomes DEPTH; wr_ptr SHALL NOT wrap.
REQ-022 OVF: s_ready=1, core_rst=1, transfers discarded (memory unchanged), load_err set on first discarded word; transfer with s_last=1 -> RUN.
REQ-023 OVF entered with DEPTH words exactly, followed by a single s_last word: that word is discarded and load_err=1.
REQ-024 RUN: s_ready=0, core_rst=0, load_done=1; start=1 -> LOAD next cycle with same clearing as REQ-018.
REQ-025 core_rst and load_done decode directly from the state register: first cycle in RUN has core_rst=0, load_done=1.
REQ-026 start is ignored in LOAD and OVF.
REQ-027 fetch_data is combinational: mem[fetch_addr] when fetch_addr < word_count, else 8'h00 (NOP) in every state.
REQ-028 A write and fetch to the same address in one cycle return the old contents.
REQ-029 load_err holds its value through RUN until the next start.

Reset
REQ-030 rst=1 at any clock edge, including mid-LOAD or OVF: state=IDLE, wr_ptr=0, word_count=0, load_err=0, s_ready=0, core_rst=1, load_done=0.
REQ-031 Memory contents are not reset; REQ-027 masking makes them unobservable after reset.
REQ-032 rst has priority over start and transfers in the same cycle.

Structure
REQ-033 Shared package imem_loader_pkg SHALL hold the state enumeration, INSTR_W=8 and NOP_INSTR=8'h00.
REQ-034 Storage SHALL be a sub-module imem_array: one synchronous write port, one asynchronous read port, DEPTH x 8.

Verification
REQ-035 Reset, start, 3 words 8'h4A, 8'h91, 8'hC3 (last on third) -> RUN, word_count=3, fetch 0..2 return those words, fetch 3 returns 8'h00, core_rst falls the cycle after the last transfer.
REQ-036 DEPTH=16, 18 words (last on 18th) -> 16 words stored, word_count=16, load_err=1, fetch 15 returns word 16, core_rst=0 after the 18th word.
REQ-037 s_valid toggling 1,0,1,0 during LOAD with 4 words -> exactly 4 writes, word_count=4, no write on idle cycles.
REQ-038 rst asserted after 2 of 5 words -> IDLE, word_count=0, fetch 0 returns 8'h00, core_rst=1; further s_valid ignored.
REQ-039 In RUN with 3 words, start then 1 word 8'h7F (last) -> core_rst=1 during reload, word_count=1, fetch 0=8'h7F, fetch 1=8'h00, load_err=0.
REQ-040 start asserted in LOAD, and start with rst in the same cycle -> no state change, and IDLE respectively.
